mdu_ctrl: RTL

- Parametrised multiply/divide unit for the next CPU generation: decodes MIPS R-type mult/div/move-HI/LO functs and runs iterative signed/unsigned multiply and divide.
- Owns HI/LO and produces a stall request to the pipeline while an operation is in flight.
- Sits beside the ALU in the execute stage; the main decoder qualifies R-type instructions via op_valid.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_sign_fix.sv | 12 +
 rtl/mdu_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states, decode helper.
package mdu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        case (f)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both for operand magnitudes and result signs.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MIPS multiply/divide unit owning HI/LO, with a pipeline stall while an op is in flight.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mf_data
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned ACC_W = 2 * XLEN;

    mdu_state_e state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc, acc_step;
    logic [XLEN-1:0]  opnd;
    logic [XLEN-1:0]  rs_raw;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             recognised, accept, start_mul, start_div, is_signed;
    logic             neg_rs, neg_rt;
    logic [XLEN-1:0]  rs_abs, rt_abs;
    logic [XLEN:0]    mul_sum, div_trial;
    logic [ACC_W-1:0] prod_fixed;
    logic [XLEN-1:0]  quo_fixed, rem_fixed;

    mdu_sign_fix #(.W(XLEN))  u_abs_rs  (.neg(neg_rs),  .a(rs_data),          .y(rs_abs));
    mdu_sign_fix #(.W(XLEN))  u_abs_rt  (.neg(neg_rt),  .a(rt_data),          .y(rt_abs));
    mdu_sign_fix #(.W(ACC_W)) u_fix_prd (.neg(neg_res), .a(acc),              .y(prod_fixed));
    mdu_sign_fix #(.W(XLEN))  u_fix_quo (.neg(neg_res), .a(acc[XLEN-1:0]),    .y(quo_fixed));
    mdu_sign_fix #(.W(XLEN))  u_fix_rem (.neg(neg_rem), .a(acc[ACC_W-1:XLEN]), .y(rem_fixed));

    // Decode, interlock, next state and one datapath iteration
    always_comb begin
        state_next = state;
        acc_step   = acc;
        mf_data    = '0;

        recognised = is_mdu_funct(funct);
        stall      = op_valid & busy & recognised;
        accept     = op_valid & ~stall & recognised;
        start_mul  = accept & ((funct == FN_MULT) | (funct == FN_MULTU));
        start_div  = accept & ((funct == FN_DIV)  | (funct == FN_DIVU));
        is_signed  = (funct == FN_MULT) | (funct == FN_DIV);
        neg_rs     = is_signed & rs_data[XLEN-1];
        neg_rt     = is_signed & rt_data[XLEN-1];

        // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right
        mul_sum   = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        // Restoring divide: trial-subtract divisor from the remainder shifted left by one dividend bit
        div_trial = {acc[ACC_W-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};

        if (funct == FN_MFHI) begin
            mf_data = hi;
        end else if (funct == FN_MFLO) begin
            mf_data = lo;
        end

        case (state)
            IDLE: begin
                if (start_mul) begin
                    state_next = MUL;
                end else if (start_div) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                acc_step = {mul_sum, acc[XLEN-1:1]};
                if (cnt == CNT_W'(1)) state_next = FIX;
            end
            DIV: begin
                if (!div_trial[XLEN]) begin
                    acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                end else begin
                    acc_step = {acc[ACC_W-2:0], 1'b0};
                end
                if (cnt == CNT_W'(1)) state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            rs_raw   <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            acc  <= acc_step;

            if (state == MUL || state == DIV) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Multiplier sits in the low half of acc for MUL; dividend sits there for DIV
            if (start_mul || start_div) begin
                cnt      <= CNT_W'(XLEN);
                acc      <= {XLEN'(0), start_div ? rs_abs : rt_abs};
                opnd     <= start_div ? rt_abs : rs_abs;
                rs_raw   <= rs_data;
                op_div   <= start_div;
                neg_res  <= neg_rs ^ neg_rt;
                neg_rem  <= neg_rs;
                div_zero <= (rt_data == '0);
            end

            if (accept && funct == FN_MTHI) hi <= rs_data;
            if (accept && funct == FN_MTLO) lo <= rs_data;

            if (state == FIX) begin
                if (!op_div) begin
                    {hi, lo} <= prod_fixed;
                end else if (div_zero) begin
                    hi <= rs_raw;
                    lo <= '1;
                end else begin
                    hi <= rem_fixed;
                    lo <= quo_fixed;
                end
            end
        end
    end

endmodule
